// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
// Shares the single-port 8-bit feature memory between requester A (pixel /
// feature writer) and requester B (texture classifier reader). A round-robin
// pointer picks the owner when both request together. The owner's burst of
// 1..16 beats is then driven onto the memory pins, one access per cycle.
// This block is the only driver of mem_en / mem_rw / mem_abus / mem_dbus_in.

module mem_access_arbiter #(
  parameter int MEM_DEPTH = 128,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          reset,

  // requester A
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [3:0]    a_len,
  input  logic [7:0]    a_wdata,
  output logic          a_gnt,
  output logic          a_beat,
  output logic          a_rvalid,
  output logic          a_done,

  // requester B
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [3:0]    b_len,
  input  logic [7:0]    b_wdata,
  output logic          b_gnt,
  output logic          b_beat,
  output logic          b_rvalid,
  output logic          b_done,

  // shared read data
  output logic [7:0]    rdata,

  // memory pins
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_abus,
  output logic [7:0]    mem_dbus_in,
  input  logic [7:0]    mem_dbus_out
);

  // Highest legal word address; the burst address wraps from here back to 0.
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic          owner_b;    // 1: B owns the current burst, 0: A owns it
  logic          prio_b;     // round-robin pointer, 1: B wins a tie
  logic [3:0]    len_q;      // latched beats-minus-one of the current burst
  logic [3:0]    cnt;        // beats already issued, minus one
  logic          win_b;      // arbitration result for this cycle
  logic [AW-1:0] abus_next;  // next burst address with wrap

  // Arbitration: a lone requester wins; on a tie the round-robin pointer decides.
  always_comb begin
    win_b = b_req & (~a_req | prio_b);
  end

  // Burst address advance, wrapping at the end of the memory.
  always_comb begin
    abus_next = (mem_abus == LAST_ADDR) ? '0 : mem_abus + AW'(1);
  end

  // Beats are qualified by the registered enable so a grant never issues early.
  assign a_beat = mem_en & a_gnt;
  assign b_beat = mem_en & b_gnt;

  // Write data goes straight from the owner to the memory; zero otherwise.
  always_comb begin
    mem_dbus_in = 8'h00;
    if (mem_en && !mem_rw) begin
      mem_dbus_in = owner_b ? b_wdata : a_wdata;
    end
  end

  // Arbitration FSM, burst sequencing and read-data capture.
  // NOTE: every register here uses non-blocking assignment so all flops see
  // the pre-edge values of each other, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner_b  <= 1'b0;
      prio_b   <= 1'b0;
      len_q    <= 4'd0;
      cnt      <= 4'd0;
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      a_done   <= 1'b0;
      b_done   <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      rdata    <= 8'h00;
      mem_en   <= 1'b0;
      mem_rw   <= 1'b0;
      mem_abus <= '0;
    end else begin
      // Done is a single-cycle pulse; only the BUSY exit raises it.
      a_done <= 1'b0;
      b_done <= 1'b0;

      // Memory read data is combinational, so capture it on every read beat;
      // the owner's rvalid follows one cycle behind its beat.
      a_rvalid <= a_beat & mem_rw;
      b_rvalid <= b_beat & mem_rw;
      if (mem_en && mem_rw) begin
        rdata <= mem_dbus_out;
      end

      unique case (state)
        IDLE: begin
          if (a_req || b_req) begin
            owner_b  <= win_b;
            a_gnt    <= ~win_b;
            b_gnt    <= win_b;
            mem_en   <= 1'b1;
            mem_rw   <= win_b ? ~b_we : ~a_we;
            mem_abus <= win_b ? b_addr : a_addr;
            len_q    <= win_b ? b_len : a_len;
            cnt      <= 4'd0;
            state    <= BUSY;
          end
        end

        BUSY: begin
          // Requests and inputs are ignored here; the latched burst runs out.
          mem_abus <= abus_next;
          if (cnt == len_q) begin
            mem_en <= 1'b0;
            a_done <= ~owner_b;
            b_done <= owner_b;
            state  <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        DONE: begin
          // Hand priority to the requester that was not just served.
          a_gnt  <= 1'b0;
          b_gnt  <= 1'b0;
          prio_b <= ~owner_b;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter
// Directed vector table for the basic write / read-back / wrap cases, hand
// sequences for contention and mid-burst reset, and a randomized phase checked
// against a transaction-level model (round-robin rule plus a reference memory).

module tb_mem_access_arbiter;

  localparam int DEPTH = 128;

  logic       clk;
  logic       reset;
  logic       a_req, a_we;
  logic [7:0] a_addr;
  logic [3:0] a_len;
  logic [7:0] a_wdata;
  logic       a_gnt, a_beat, a_rvalid, a_done;
  logic       b_req, b_we;
  logic [7:0] b_addr;
  logic [3:0] b_len;
  logic [7:0] b_wdata;
  logic       b_gnt, b_beat, b_rvalid, b_done;
  logic [7:0] rdata;
  logic       mem_en, mem_rw;
  logic [7:0] mem_abus;
  logic [7:0] mem_dbus_in;
  logic [7:0] mem_dbus_out;

  mem_access_arbiter #(.MEM_DEPTH(DEPTH), .AW(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .a_req        (a_req),
    .a_we         (a_we),
    .a_addr       (a_addr),
    .a_len        (a_len),
    .a_wdata      (a_wdata),
    .a_gnt        (a_gnt),
    .a_beat       (a_beat),
    .a_rvalid     (a_rvalid),
    .a_done       (a_done),
    .b_req        (b_req),
    .b_we         (b_we),
    .b_addr       (b_addr),
    .b_len        (b_len),
    .b_wdata      (b_wdata),
    .b_gnt        (b_gnt),
    .b_beat       (b_beat),
    .b_rvalid     (b_rvalid),
    .b_done       (b_done),
    .rdata        (rdata),
    .mem_en       (mem_en),
    .mem_rw       (mem_rw),
    .mem_abus     (mem_abus),
    .mem_dbus_in  (mem_dbus_in),
    .mem_dbus_out (mem_dbus_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The memory device itself: combinational read, write on the clock edge.
  logic [7:0] dev_mem [DEPTH] = '{default: 8'h00};
  assign mem_dbus_out = dev_mem[mem_abus[6:0]];
  always @(posedge clk) begin
    if (mem_en && !mem_rw) dev_mem[mem_abus[6:0]] <= mem_dbus_in;
  end

  // Reference model state: expected memory contents and round-robin pointer.
  logic [7:0] ref_mem [DEPTH] = '{default: 8'h00};
  bit         prio_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       en;
    logic       rw;
    logic [7:0] abus;
    logic [1:0] gnt;    // {b, a}
    logic [1:0] beat;
    logic [1:0] rv;
    logic [1:0] done;
    logic [7:0] rdata;
    logic [7:0] dbus;
  } exp_t;

  typedef struct {
    logic [1:0] req;    // {b, a}
    logic       we;
    logic [7:0] addr;
    logic [3:0] len;
    logic [7:0] wd;
    exp_t       e;
  } vec_t;

  vec_t tv [23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input exp_t e, input string tag);
    check({tag, ".en"},   32'(mem_en), 32'(e.en));
    if (e.en) begin
      check({tag, ".rw"},   32'(mem_rw),   32'(e.rw));
      check({tag, ".abus"}, 32'(mem_abus), 32'(e.abus));
    end
    check({tag, ".gnt"},    32'({b_gnt, a_gnt}),       32'(e.gnt));
    check({tag, ".beat"},   32'({b_beat, a_beat}),     32'(e.beat));
    check({tag, ".rvalid"}, 32'({b_rvalid, a_rvalid}), 32'(e.rv));
    check({tag, ".done"},   32'({b_done, a_done}),     32'(e.done));
    if (e.rv != 2'b00) check({tag, ".rdata"}, 32'(rdata), 32'(e.rdata));
    check({tag, ".dbus"},   32'(mem_dbus_in), 32'(e.dbus));
  endtask

  function automatic vec_t mk(logic [1:0] req, logic we, logic [7:0] addr, logic [3:0] len,
                              logic [7:0] wd, logic en, logic rw, logic [7:0] abus,
                              logic [1:0] gnt, logic [1:0] beat, logic [1:0] rv,
                              logic [1:0] done, logic [7:0] rd, logic [7:0] dbus);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.len = len; v.wd = wd;
    v.e = '{en: en, rw: rw, abus: abus, gnt: gnt, beat: beat, rv: rv,
            done: done, rdata: rd, dbus: dbus};
    return v;
  endfunction

  function automatic logic [7:0] wrap(int x);
    return 8'(x % DEPTH);
  endfunction

  // Round-robin rule: a lone requester wins, a tie goes to the pointer.
  function automatic bit pick_b(bit ra, bit rb);
    return rb && (!ra || prio_b);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    prio_b = 1'b0;
  endtask

  // Checks one whole burst from the cycle its request is first seen in IDLE
  // through the done cycle, using the requester inputs as they stand now.
  task automatic run_burst(input bit own_b, input bit keep);
    logic       we;
    logic [7:0] addr;
    logic [3:0] len;
    logic [7:0] wd;
    logic [1:0] who;
    exp_t       e;
    int         n;
    we   = own_b ? b_we   : a_we;
    addr = own_b ? b_addr : a_addr;
    len  = own_b ? b_len  : a_len;
    who  = own_b ? 2'b10 : 2'b01;
    n    = int'(len) + 1;
    #1;
    e = '0;
    check_outs(e, "present");
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      wd = 8'($urandom);
      // The owner's burst parameters may wander after grant without effect.
      if (own_b) begin
        b_wdata = wd; a_wdata = 8'($urandom);
        b_we = 1'($urandom); b_addr = 8'($urandom_range(0, 127)); b_len = 4'($urandom);
      end else begin
        a_wdata = wd; b_wdata = 8'($urandom);
        a_we = 1'($urandom); a_addr = 8'($urandom_range(0, 127)); a_len = 4'($urandom);
      end
      #1;
      e = '0;
      e.en   = 1'b1;
      e.rw   = ~we;
      e.abus = wrap(int'(addr) + k);
      e.gnt  = who;
      e.beat = who;
      if (!we && k > 0) begin
        e.rv    = who;
        e.rdata = ref_mem[wrap(int'(addr) + k - 1)];
      end
      e.dbus = we ? wd : 8'h00;
      check_outs(e, "beat");
      if (we) ref_mem[wrap(int'(addr) + k)] = wd;
    end
    @(negedge clk);
    #1;
    e = '0;
    e.gnt  = who;
    e.done = who;
    if (!we) begin
      e.rv    = who;
      e.rdata = ref_mem[wrap(int'(addr) + n - 1)];
    end
    check_outs(e, "done");
    if (!keep) begin
      if (own_b) b_req = 1'b0; else a_req = 1'b0;
    end
    prio_b = ~own_b;
  endtask

  initial begin
    bit both, own;

    // Directed vectors: A writes 05..07, B reads them back, A writes across
    // the wrap point, B reads that back.
    tv[0]  = mk(2'b01, 1, 8'h05, 2, 8'h00, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
    tv[1]  = mk(2'b01, 1, 8'h05, 2, 8'h11, 1, 0, 8'h05, 2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 8'h11);
    tv[2]  = mk(2'b01, 1, 8'h05, 2, 8'h22, 1, 0, 8'h06, 2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 8'h22);
    tv[3]  = mk(2'b01, 1, 8'h05, 2, 8'h33, 1, 0, 8'h07, 2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 8'h33);
    tv[4]  = mk(2'b00, 0, 8'h00, 0, 8'h44, 0, 0, 8'h00, 2'b01, 2'b00, 2'b00, 2'b01, 8'h00, 8'h00);
    tv[5]  = mk(2'b10, 0, 8'h05, 2, 8'h5a, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
    tv[6]  = mk(2'b10, 0, 8'h05, 2, 8'h5a, 1, 1, 8'h05, 2'b10, 2'b10, 2'b00, 2'b00, 8'h00, 8'h00);
    tv[7]  = mk(2'b10, 0, 8'h05, 2, 8'h5a, 1, 1, 8'h06, 2'b10, 2'b10, 2'b10, 2'b00, 8'h11, 8'h00);
    tv[8]  = mk(2'b10, 0, 8'h05, 2, 8'h5a, 1, 1, 8'h07, 2'b10, 2'b10, 2'b10, 2'b00, 8'h22, 8'h00);
    tv[9]  = mk(2'b00, 0, 8'h00, 0, 8'h5a, 0, 0, 8'h00, 2'b10, 2'b00, 2'b10, 2'b10, 8'h33, 8'h00);
    tv[10] = mk(2'b01, 1, 8'h7e, 3, 8'h00, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
    tv[11] = mk(2'b01, 1, 8'h7e, 3, 8'haa, 1, 0, 8'h7e, 2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 8'haa);
    tv[12] = mk(2'b01, 1, 8'h7e, 3, 8'hbb, 1, 0, 8'h7f, 2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 8'hbb);
    tv[13] = mk(2'b01, 1, 8'h7e, 3, 8'hcc, 1, 0, 8'h00, 2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 8'hcc);
    tv[14] = mk(2'b01, 1, 8'h7e, 3, 8'hdd, 1, 0, 8'h01, 2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 8'hdd);
    tv[15] = mk(2'b00, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 2'b01, 2'b00, 2'b00, 2'b01, 8'h00, 8'h00);
    tv[16] = mk(2'b10, 0, 8'h7e, 3, 8'h5a, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);
    tv[17] = mk(2'b10, 0, 8'h7e, 3, 8'h5a, 1, 1, 8'h7e, 2'b10, 2'b10, 2'b00, 2'b00, 8'h00, 8'h00);
    tv[18] = mk(2'b10, 0, 8'h7e, 3, 8'h5a, 1, 1, 8'h7f, 2'b10, 2'b10, 2'b10, 2'b00, 8'haa, 8'h00);
    tv[19] = mk(2'b10, 0, 8'h7e, 3, 8'h5a, 1, 1, 8'h00, 2'b10, 2'b10, 2'b10, 2'b00, 8'hbb, 8'h00);
    tv[20] = mk(2'b10, 0, 8'h7e, 3, 8'h5a, 1, 1, 8'h01, 2'b10, 2'b10, 2'b10, 2'b00, 8'hcc, 8'h00);
    tv[21] = mk(2'b00, 0, 8'h00, 0, 8'h5a, 0, 0, 8'h00, 2'b10, 2'b00, 2'b10, 2'b10, 8'hdd, 8'h00);
    tv[22] = mk(2'b00, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00);

    // Reset with requests and write data active: everything must read 0.
    reset = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h33; a_len = 4'd3; a_wdata = 8'hff;
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h44; b_len = 4'd3; b_wdata = 8'hee;
    repeat (2) @(negedge clk);
    #1;
    check("rst.outs", 32'({mem_en, mem_rw, a_gnt, a_beat, a_rvalid, a_done,
                           b_gnt, b_beat, b_rvalid, b_done}), 32'd0);
    check("rst.abus",  32'(mem_abus),    32'd0);
    check("rst.rdata", 32'(rdata),       32'd0);
    check("rst.dbus",  32'(mem_dbus_in), 32'd0);
    reset = 1'b0; a_req = 1'b0; b_req = 1'b0;
    prio_b = 1'b0;

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      a_req = tv[i].req[0];  b_req = tv[i].req[1];
      a_we  = tv[i].we;      b_we  = tv[i].we;
      a_addr = tv[i].addr;   b_addr = tv[i].addr;
      a_len = tv[i].len;     b_len = tv[i].len;
      a_wdata = tv[i].wd;    b_wdata = tv[i].wd;
      #1;
      check_outs(tv[i].e, $sformatf("vec%0d", i));
    end
    // Model catch-up for the table: known writes, and B was served last.
    ref_mem[5] = 8'h11; ref_mem[6] = 8'h22; ref_mem[7] = 8'h33;
    ref_mem[126] = 8'haa; ref_mem[127] = 8'hbb; ref_mem[0] = 8'hcc; ref_mem[1] = 8'hdd;
    prio_b = 1'b0;

    // Fill the whole memory with random data through A, 16-beat bursts.
    for (int blk = 0; blk < 8; blk++) begin
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b1; a_addr = 8'(blk * 16); a_len = 4'd15;
      run_burst(1'b0, 1'b0);
    end

    // Randomized traffic: lone or simultaneous requests, mixed directions.
    for (int r = 0; r < 60; r++) begin
      @(negedge clk);
      case ($urandom_range(0, 2))
        0:       begin a_req = 1'b1; b_req = 1'b0; end
        1:       begin a_req = 1'b0; b_req = 1'b1; end
        default: begin a_req = 1'b1; b_req = 1'b1; end
      endcase
      a_we = 1'($urandom); b_we = 1'($urandom);
      a_len = 4'($urandom); b_len = 4'($urandom);
      a_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(120, 127)) : 8'($urandom_range(0, 127));
      b_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(120, 127)) : 8'($urandom_range(0, 127));
      both = a_req && b_req;
      own  = pick_b(a_req, b_req);
      run_burst(own, 1'b0);
      if (both) begin
        @(negedge clk);
        run_burst(~own, 1'b0);
      end
    end

    // Contention out of reset with both requests held: A, B, A, then B.
    do_reset();
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10; a_len = 4'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h20; b_len = 4'd2;
    run_burst(1'b0, 1'b1);
    @(negedge clk);
    run_burst(1'b1, 1'b1);
    @(negedge clk);
    run_burst(1'b0, 1'b0);
    @(negedge clk);
    run_burst(1'b1, 1'b0);

    // Reset during beat 2 of a 16-beat B read, with A waiting.
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h20; b_len = 4'd15;
    #1;
    check("mid.idle_gnt", 32'({b_gnt, a_gnt}), 32'd0);
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h40; a_len = 4'd2;
    #1;
    check("mid.beat1", 32'({mem_en, b_beat, a_beat}), 32'b110);
    check("mid.abus1", 32'(mem_abus), 32'h20);
    @(negedge clk);
    #1;
    check("mid.beat2", 32'({mem_en, b_beat}), 32'b11);
    check("mid.abus2", 32'(mem_abus), 32'h21);
    check("mid.rv2",   32'(b_rvalid), 32'd1);
    check("mid.rd2",   32'(rdata),    32'(ref_mem[8'h20]));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; b_req = 1'b0;
    prio_b = 1'b0;
    #1;
    check("mid.after_en",    32'(mem_en), 32'd0);
    check("mid.after_gnt",   32'({b_gnt, a_gnt}), 32'd0);
    check("mid.after_done",  32'({b_done, a_done}), 32'd0);
    check("mid.after_rv",    32'({b_rvalid, a_rvalid}), 32'd0);
    check("mid.after_rdata", 32'(rdata), 32'd0);
    run_burst(1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("end.idle", 32'({mem_en, a_gnt, b_gnt, a_done, b_done}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
